// File: rtl/led_zone_pkg.sv
// rtl/led_zone_pkg.sv - shared constants, mean types and FSM states for the zone mean block
package led_zone_pkg;

   localparam int ZONE_NUM   = 8;
   localparam int ZONE_IDX_W = 3;
   localparam int PIX_W      = 8;
   localparam int MEAN_W     = 4;

   typedef logic [MEAN_W-1:0]    mean_t;
   typedef mean_t [ZONE_NUM-1:0] mean_arr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_DONE
   } zone_st_e;

endpackage

// File: rtl/zone_acc.sv
// rtl/zone_acc.sv - eight per-zone accumulators for one colour channel
module zone_acc
   import led_zone_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic                  clk_fast,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  add,
   input  logic [ZONE_IDX_W-1:0] zone,
   input  logic [PIX_W-1:0]      pix,
   output mean_arr_t             mean
);

   logic [ACC_W-1:0] acc [ZONE_NUM];
   logic [ACC_W-1:0] pix_ext;

   assign pix_ext = ACC_W'(pix);

   // load starts a new frame: the selected zone takes the pixel, all others clear
   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ZONE_NUM; i++) acc[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < ZONE_NUM; i++)
            acc[i] <= (zone == ZONE_IDX_W'(i)) ? pix_ext : '0;
      end else if (add) begin
         acc[zone] <= acc[zone] + pix_ext;
      end
   end

   // a full zone holds exactly 2^S pixels, so the top nibble is the truncated mean
   always_comb begin
      for (int i = 0; i < ZONE_NUM; i++) mean[i] = acc[i][ACC_W-1 -: MEAN_W];
   end

endmodule

// File: rtl/led_zone_mean.sv
// rtl/led_zone_mean.sv - per-zone RGB frame means with end-of-frame start pulse
module led_zone_mean
   import led_zone_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int IMG_H = 128
) (
   input  logic             clk_fast,
   input  logic             rstn,
   input  logic             sof_i,
   input  logic             pix_vld_i,
   input  logic [PIX_W-1:0] pix_r_i,
   input  logic [PIX_W-1:0] pix_g_i,
   input  logic [PIX_W-1:0] pix_b_i,
   output mean_arr_t        MeanR,
   output mean_arr_t        MeanG,
   output mean_arr_t        MeanB,
   output logic             start_o,
   output logic             frame_err_o
);

   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int YCW   = (YW > 0) ? YW : 1;
   localparam int S     = XW + YW - ZONE_IDX_W;
   localparam int ACC_W = PIX_W + S;
   localparam logic [XW-1:0]  X_LAST = XW'(IMG_W - 1);
   localparam logic [YCW-1:0] Y_LAST = YCW'(IMG_H - 1);

   zone_st_e st, st_nx;
   logic [XW-1:0]  x, x_nx;
   logic [YCW-1:0] y, y_nx;
   logic sof_v, acc_load, acc_add, latch, err;
   logic [ZONE_IDX_W-1:0] zone_sel;
   mean_arr_t acc_mean_r, acc_mean_g, acc_mean_b;

   assign sof_v    = sof_i & pix_vld_i;
   assign zone_sel = acc_load ? '0 : x[XW-1 -: ZONE_IDX_W];

   always_comb begin
      st_nx    = st;
      x_nx     = x;
      y_nx     = y;
      acc_load = 1'b0;
      acc_add  = 1'b0;
      latch    = 1'b0;
      err      = 1'b0;
      unique case (st)
         ST_IDLE: begin
            if (sof_v) begin
               acc_load = 1'b1;
               x_nx     = XW'(1);
               y_nx     = '0;
               st_nx    = ST_ACC;
            end
         end
         ST_ACC: begin
            if (pix_vld_i) begin
               if (sof_i) begin
                  err      = 1'b1;
                  acc_load = 1'b1;
                  x_nx     = XW'(1);
                  y_nx     = '0;
               end else begin
                  acc_add = 1'b1;
                  if (x == X_LAST) begin
                     x_nx = '0;
                     if (y == Y_LAST) begin
                        y_nx  = '0;
                        st_nx = ST_DONE;
                     end else begin
                        y_nx = y + 1'b1;
                     end
                  end else begin
                     x_nx = x + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            // means are taken from the accumulators before a same-cycle restart clears them
            latch = 1'b1;
            st_nx = ST_IDLE;
            if (sof_v) begin
               acc_load = 1'b1;
               x_nx     = XW'(1);
               y_nx     = '0;
               st_nx    = ST_ACC;
            end
         end
         default: st_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
         st          <= ST_IDLE;
         x           <= '0;
         y           <= '0;
         MeanR       <= '0;
         MeanG       <= '0;
         MeanB       <= '0;
         start_o     <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         st          <= st_nx;
         x           <= x_nx;
         y           <= y_nx;
         start_o     <= latch;
         frame_err_o <= err;
         if (latch) begin
            MeanR <= acc_mean_r;
            MeanG <= acc_mean_g;
            MeanB <= acc_mean_b;
         end
      end
   end

   zone_acc #(.ACC_W(ACC_W)) u_acc_r (
      .clk_fast (clk_fast),
      .rstn     (rstn),
      .load     (acc_load),
      .add      (acc_add),
      .zone     (zone_sel),
      .pix      (pix_r_i),
      .mean     (acc_mean_r)
   );

   zone_acc #(.ACC_W(ACC_W)) u_acc_g (
      .clk_fast (clk_fast),
      .rstn     (rstn),
      .load     (acc_load),
      .add      (acc_add),
      .zone     (zone_sel),
      .pix      (pix_g_i),
      .mean     (acc_mean_g)
   );

   zone_acc #(.ACC_W(ACC_W)) u_acc_b (
      .clk_fast (clk_fast),
      .rstn     (rstn),
      .load     (acc_load),
      .add      (acc_add),
      .zone     (zone_sel),
      .pix      (pix_b_i),
      .mean     (acc_mean_b)
   );

endmodule
